// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch, req/gnt issue, in-order responses, redirect flush.
// Optional FETCH_BYPASS_EN: a response into an empty queue is presented to decode in the same cycle.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [XLEN-1:0]            pc_init_i,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic                       imem_req_o,
  output logic [XLEN-1:0]            imem_addr_o,
  input  logic                       imem_gnt_i,
  input  logic                       imem_rvalid_i,
  input  logic [31:0]                imem_rdata_i,
  output logic                       instr_valid_o,
  input  logic                       instr_ready_i,
  output logic [31:0]                instr_o,
  output logic [XLEN-1:0]            pc_o,
  output logic [XLEN-1:0]            pc_next_4_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  // Discarded requests are not credit-limited, so the in-flight counter gets headroom.
  localparam int OW  = $clog2(DEPTH) + 4;
  localparam int OW1 = OW + 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [AW-1:0]   rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [CW-1:0]   count;
  logic [OW-1:0]   outstanding, discard;

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] pc4_mem   [DEPTH];
  logic [XLEN-1:0] tag_mem   [DEPTH];

  logic            gnt_fire, resp_fire, resp_keep, bypass, push, pop;
  logic [OW-1:0]   live, out_next;
  logic [OW1-1:0]  credit;
  logic [XLEN-1:0] resp_pc;

  // Credit covers queued entries plus live (non-discarded) requests still in flight.
  assign live       = outstanding - discard;
  assign credit     = OW1'(live) + OW1'(count);
  assign imem_req_o = (state == S_RUN) && (credit < OW1'(DEPTH)) && (outstanding != '1);
  assign imem_addr_o = fetch_pc;

  assign gnt_fire  = imem_req_o & imem_gnt_i;
  assign resp_fire = imem_rvalid_i & (outstanding != '0);
  assign resp_keep = resp_fire & (discard == '0) & ~redirect_i;
  assign resp_pc   = tag_mem[tag_rd];
  assign out_next  = outstanding + OW'(gnt_fire) - OW'(resp_fire);

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_keep & (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign pop  = (state == S_RUN) & (count != '0) & instr_ready_i & ~redirect_i;
  assign push = resp_keep & ~(bypass & instr_ready_i);

  assign instr_valid_o = (count != '0) | bypass;
  assign instr_o       = bypass ? imem_rdata_i       : instr_mem[rd_ptr];
  assign pc_o          = bypass ? resp_pc            : pc_mem[rd_ptr];
  assign pc_next_4_o   = bypass ? resp_pc + XLEN'(4) : pc4_mem[rd_ptr];
  assign count_o       = count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= S_INIT;
      fetch_pc    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      // NOTE: the small arrays are reset so head payload outputs read 0 out of reset, not X.
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
        pc4_mem[i]   <= '0;
        tag_mem[i]   <= '0;
      end
    end else begin
      case (state)
        S_INIT: begin
          state    <= S_RUN;
          fetch_pc <= pc_init_i;
        end
        S_RUN: begin
          outstanding <= out_next;
          if (redirect_i) begin
            // Everything still in flight after this edge belongs to the old path.
            discard  <= out_next;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
            fetch_pc <= redirect_pc_i;
          end else begin
            if (resp_fire && discard != '0) discard <= discard - OW'(1);
            if (resp_fire && discard == '0) tag_rd <= tag_rd + AW'(1);
            if (gnt_fire) begin
              tag_mem[tag_wr] <= fetch_pc;
              tag_wr          <= tag_wr + AW'(1);
              fetch_pc        <= fetch_pc + XLEN'(4);
            end
            if (push) begin
              instr_mem[wr_ptr] <= imem_rdata_i;
              pc_mem[wr_ptr]    <= resp_pc;
              pc4_mem[wr_ptr]   <= resp_pc + XLEN'(4);
              wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  rvalid_has_request: assert property (@(posedge clk_i) disable iff (!rst_i)
    imem_rvalid_i |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table, hand sequences and a randomized run against
// a queue-based reference model. Honours FETCH_BYPASS_EN the same way as the design.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 64;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [63:0] A = 64'h0000_0000_8000_0000;

  logic        clk_i = 1'b0, rst_i = 1'b0;
  logic [63:0] pc_init_i = A, redirect_pc_i = '0;
  logic        redirect_i = 0, imem_gnt_i = 0, imem_rvalid_i = 0, instr_ready_i = 0;
  logic [31:0] imem_rdata_i = '0;
  logic        imem_req_o, instr_valid_o;
  logic [63:0] imem_addr_o, pc_o, pc_next_4_o;
  logic [31:0] instr_o;
  logic [2:0]  count_o;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_init_i(pc_init_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_o(instr_o),
    .pc_o(pc_o), .pc_next_4_o(pc_next_4_o), .count_o(count_o));

  always #5 clk_i = ~clk_i;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: queue contents and in-flight requests as plain SV queues.
  typedef struct { logic [31:0] instr; logic [63:0] pc; } entry_t;
  typedef struct { logic [63:0] pc; bit drop; } flight_t;
  entry_t      mq[$];
  flight_t     mf[$];
  bit          m_run;
  logic [63:0] m_fpc;

  function automatic int m_live();
    int n = 0;
    foreach (mf[i]) if (!mf[i].drop) n++;
    return n;
  endfunction

  function automatic bit m_req();
    return m_run && (mq.size() + m_live() < DEPTH);
  endfunction

  function automatic bit m_byp();
    return BYP && m_run && mq.size() == 0 && mf.size() > 0 && m_live() == mf.size()
           && !redirect_i && imem_rvalid_i;
  endfunction

  task automatic model_reset();
    mq.delete(); mf.delete(); m_run = 0; m_fpc = '0;
  endtask

  task automatic apply();
    entry_t h;
    bit     v;
    #1;
    v = (mq.size() > 0) || m_byp();
    check("req", imem_req_o, m_req());
    check("addr", imem_addr_o, m_fpc);
    check("count", count_o, mq.size());
    check("valid", instr_valid_o, v);
    if (v) begin
      if (mq.size() > 0) h = mq[0];
      else h = '{imem_rdata_i, mf[0].pc};
      check("instr", instr_o, h.instr);
      check("pc", pc_o, h.pc);
      check("pc_next_4", pc_next_4_o, h.pc + 64'd4);
    end
  endtask

  task automatic advance();
    bit g, r, b;
    flight_t f;
    g = m_req() && imem_gnt_i;
    r = imem_rvalid_i && mf.size() > 0;
    b = m_byp();
    @(posedge clk_i);
    if (!m_run) begin
      m_run = 1; m_fpc = pc_init_i;
    end else if (redirect_i) begin
      if (r) void'(mf.pop_front());
      if (g) mf.push_back('{m_fpc, 1'b0});
      foreach (mf[i]) mf[i].drop = 1'b1;
      mq.delete();
      m_fpc = redirect_pc_i;
    end else begin
      if (mq.size() > 0 && instr_ready_i) void'(mq.pop_front());
      if (r) begin
        f = mf.pop_front();
        if (!f.drop && !(b && instr_ready_i)) mq.push_back('{imem_rdata_i, f.pc});
      end
      if (g) begin
        mf.push_back('{m_fpc, 1'b0});
        m_fpc = m_fpc + 64'd4;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic drive(input logic g, rv, input logic [31:0] d, input logic rdy, red,
                       input logic [63:0] rpc);
    imem_gnt_i = g; imem_rvalid_i = rv; imem_rdata_i = d;
    instr_ready_i = rdy; redirect_i = red; redirect_pc_i = rpc;
  endtask

  task automatic do_reset(input logic [63:0] init);
    drive(0, 0, '0, 0, 0, '0);
    pc_init_i = init;
    rst_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_req", imem_req_o, 0);
    check("rst_addr", imem_addr_o, 0);
    check("rst_valid", instr_valid_o, 0);
    check("rst_count", count_o, 0);
    check("rst_instr", instr_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_pc4", pc_next_4_o, 0);
    rst_i = 1'b1;
  endtask

  typedef struct {
    logic g, rv, rdy, red; logic [31:0] d; logic [63:0] rpc;
    logic er; logic [63:0] ea; logic ev; int ec; logic [63:0] ep;
  } vec_t;

  function automatic vec_t v(input logic g, rv, rdy, red, input logic [31:0] d,
                             input logic [63:0] rpc, input logic er, input logic [63:0] ea,
                             input logic ev, input int ec, input logic [63:0] ep);
    return '{g, rv, rdy, red, d, rpc, er, ea, ev, ec, ep};
  endfunction

  vec_t tbl[20];

  initial begin
    int first;
    // Streaming: gnt and rvalid every cycle, decode always ready.
    do_reset(A);
    first = BYP ? 2 : 3;
    for (int k = 0; k < 10; k++) begin
      drive(1, mf.size() > 0, $urandom, 1, 0, '0);
      apply();
      if (k == first - 1) check("stream_first_valid", instr_valid_o, 0);
      if (k >= first) begin
        check("stream_valid", instr_valid_o, 1);
        check("stream_pc", pc_o, A + 64'(4 * (k - first)));
      end
      advance();
    end

    // Fill to DEPTH with ready low, pop once, then redirect with 3 outstanding.
    tbl[0]  = v(1,0,0,0, 32'h0,  '0,       0, 64'h0,    0,   0, 0);
    tbl[1]  = v(1,0,0,0, 32'h0,  '0,       1, A,        0,   0, 0);
    tbl[2]  = v(1,1,0,0, 32'hD0, '0,       1, A+'h4,    BYP, 0, A);
    tbl[3]  = v(1,1,0,0, 32'hD1, '0,       1, A+'h8,    1,   1, A);
    tbl[4]  = v(1,1,0,0, 32'hD2, '0,       1, A+'hC,    1,   2, A);
    tbl[5]  = v(1,1,0,0, 32'hD3, '0,       0, A+'h10,   1,   3, A);
    tbl[6]  = v(1,0,0,0, 32'h0,  '0,       0, A+'h10,   1,   4, A);
    tbl[7]  = v(1,0,1,0, 32'h0,  '0,       0, A+'h10,   1,   4, A);
    tbl[8]  = v(1,0,0,0, 32'h0,  '0,       1, A+'h10,   1,   3, A+'h4);
    tbl[9]  = v(1,0,0,0, 32'h0,  '0,       0, A+'h14,   1,   3, A+'h4);
    tbl[10] = v(1,1,1,0, 32'hD4, '0,       0, A+'h14,   1,   3, A+'h4);
    tbl[11] = v(1,0,1,0, 32'h0,  '0,       1, A+'h14,   1,   3, A+'h8);
    tbl[12] = v(1,0,1,0, 32'h0,  '0,       1, A+'h18,   1,   2, A+'hC);
    tbl[13] = v(1,0,1,0, 32'h0,  '0,       1, A+'h1C,   1,   1, A+'h10);
    tbl[14] = v(0,0,1,1, 32'h0,  A+'h100,  1, A+'h20,   0,   0, 0);
    tbl[15] = v(0,1,0,0, 32'hE0, '0,       1, A+'h100,  0,   0, 0);
    tbl[16] = v(1,1,0,0, 32'hE1, '0,       1, A+'h100,  0,   0, 0);
    tbl[17] = v(0,1,0,0, 32'hE2, '0,       1, A+'h104,  0,   0, 0);
    tbl[18] = v(0,1,0,0, 32'hD5, '0,       1, A+'h104,  BYP, 0, A+'h100);
    tbl[19] = v(0,0,0,0, 32'h0,  '0,       1, A+'h104,  1,   1, A+'h100);
    do_reset(A);
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].g, tbl[i].rv, tbl[i].d, tbl[i].rdy, tbl[i].red, tbl[i].rpc);
      apply();
      check($sformatf("tbl%0d_req", i), imem_req_o, tbl[i].er);
      check($sformatf("tbl%0d_addr", i), imem_addr_o, tbl[i].ea);
      check($sformatf("tbl%0d_valid", i), instr_valid_o, tbl[i].ev);
      check($sformatf("tbl%0d_count", i), count_o, tbl[i].ec);
      if (tbl[i].ev) check($sformatf("tbl%0d_pc", i), pc_o, tbl[i].ep);
      advance();
    end

    // Redirect coinciding with gnt, rvalid and pop.
    do_reset(A);
    drive(1, 0, 0, 0, 0, 0); apply(); advance();
    drive(1, 0, 0, 0, 0, 0); apply(); advance();
    drive(1, 0, 0, 0, 0, 0); apply(); advance();
    drive(1, 1, 32'h11, 0, 0, 0); apply(); advance();
    drive(1, 1, 32'h22, 1, 1, A + 'h200); apply();
    check("redir_req", imem_req_o, 1);
    advance();
    drive(0, 1, 32'h33, 1, 0, 0); apply();
    check("redir_count", count_o, 0);
    check("redir_valid", instr_valid_o, 0);
    check("redir_addr", imem_addr_o, A + 'h200);
    advance();
    drive(0, 1, 32'h44, 1, 0, 0); apply();
    check("redir_drop_valid", instr_valid_o, 0);
    advance();
    drive(1, 0, 0, 0, 0, 0); apply(); advance();
    drive(0, 1, 32'h55AA_1234, 0, 0, 0); apply();
    check("redir_resp_valid", instr_valid_o, BYP);
    advance();
    drive(0, 0, 0, 0, 0, 0); apply();
    check("redir_head_valid", instr_valid_o, 1);
    check("redir_head_pc", pc_o, A + 'h200);
    check("redir_head_instr", instr_o, 32'h55AA_1234);
    advance();

    // PC wrap at the top of the address space.
    drive(0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC); apply(); advance();
    drive(1, 0, 0, 0, 0, 0); apply();
    check("wrap_addr", imem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    advance();
    drive(1, 0, 0, 0, 0, 0); apply();
    check("wrap_next_addr", imem_addr_o, 64'h0);
    advance();
    drive(0, 1, 32'h66, 0, 0, 0); apply(); advance();
    drive(0, 0, 0, 0, 0, 0); apply();
    check("wrap_pc", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_pc4", pc_next_4_o, 64'h0);
    advance();

    // Response into an empty queue with decode ready: bypass versus registered path.
    drive(0, 0, 0, 1, 0, 0); apply(); advance();
    drive(0, 1, 32'h77, 1, 0, 0); apply();
    check("byp_valid", instr_valid_o, BYP);
    check("byp_count", count_o, 0);
    if (BYP) begin
      check("byp_pc", pc_o, 64'h0);
      check("byp_instr", instr_o, 32'h77);
    end
    advance();
    drive(0, 0, 0, 0, 0, 0); apply();
    check("byp_after_count", count_o, BYP ? 0 : 1);
    check("byp_after_valid", instr_valid_o, !BYP);
    advance();

    // Randomized traffic with varying backpressure and occasional redirects.
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] rpc;
      int rdy_pct;
      rdy_pct = ((i / 300) % 3 == 0) ? 2 : 7;
      rpc = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0;
      drive($urandom_range(0, 9) < 7, mf.size() > 0 && $urandom_range(0, 9) < 6, $urandom,
            $urandom_range(0, 9) < rdy_pct, $urandom_range(0, 19) == 0, rpc);
      apply();
      advance();
    end

    // Reset asserted mid-burst clears every output without waiting for a clock edge.
    drive(1, mf.size() > 0, 32'hABCD, 0, 0, 0);
    #2;
    rst_i = 1'b0;
    #1;
    check("midrst_req", imem_req_o, 0);
    check("midrst_addr", imem_addr_o, 0);
    check("midrst_valid", instr_valid_o, 0);
    check("midrst_count", count_o, 0);
    check("midrst_instr", instr_o, 0);
    check("midrst_pc", pc_o, 0);
    check("midrst_pc4", pc_next_4_o, 0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(1, 0, 0, 0, 0, 0); apply(); advance();
    drive(1, 0, 0, 0, 0, 0); apply(); advance();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
